// File: rtl/puf_pkg.sv
// Shared widths and FSM state type for the PUF key sampler.
package puf_pkg;

    localparam int unsigned RESP_W = 64;
    localparam int unsigned CHAL_W = 2;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StSettle,
        StSample,
        StDone
    } state_t;

endpackage

// File: rtl/puf_bit_voter.sv
// One response bit: saturating ones counter with majority and unanimity flags.
module puf_bit_voter #(
    parameter int unsigned SAMPLES = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic sample_en,
    input  logic resp_bit,
    output logic majority,
    output logic unstable
);

    localparam int unsigned CNT_W = $clog2(SAMPLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_upd;

    // Flags look at the post-sample count so the top can latch them on the final sample edge.
    always_comb begin
        cnt_upd = cnt_q;
        if (sample_en && resp_bit && (cnt_q != CNT_W'(SAMPLES))) begin
            cnt_upd = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_upd;
        end
    end

    assign majority = cnt_upd > CNT_W'(SAMPLES / 2);
    assign unstable = (cnt_upd != '0) && (cnt_upd != CNT_W'(SAMPLES));

endmodule

// File: rtl/puf_key_sampler.sv
// Repeatedly evaluates a 64-bit PUF and majority-votes the samples into a key.
module puf_key_sampler
    import puf_pkg::*;
#(
    parameter int unsigned SAMPLES       = 7,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    output logic              busy,
    output logic              puf_enable,
    output logic [CHAL_W-1:0] puf_control,
    input  logic [RESP_W-1:0] puf_response,
    output logic [RESP_W-1:0] key,
    output logic [RESP_W-1:0] unstable_mask,
    output logic              key_valid,
    input  logic              key_ready
);

    if ((SAMPLES % 2 == 0) || (SAMPLES < 3) || (SAMPLES > 15)) begin : g_bad_samples
        $error("SAMPLES must be odd and within 3..15");
    end
    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 1..255");
    end

    state_t            state_q;
    logic [7:0]        settle_q;
    logic [3:0]        round_q;
    logic              clear;
    logic              sample_en;
    logic [RESP_W-1:0] maj;
    logic [RESP_W-1:0] unst;

    assign clear     = (state_q == StIdle) && start;
    assign sample_en = (state_q == StSample);
    assign busy      = (state_q != StIdle);

    for (genvar i = 0; i < RESP_W; i++) begin : g_voter
        puf_bit_voter #(
            .SAMPLES (SAMPLES)
        ) u_voter (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .sample_en (sample_en),
            .resp_bit  (puf_response[i]),
            .majority  (maj[i]),
            .unstable  (unst[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            settle_q      <= '0;
            round_q       <= '0;
            puf_enable    <= 1'b0;
            puf_control   <= '0;
            key           <= '0;
            unstable_mask <= '0;
            key_valid     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        puf_control <= challenge;
                        round_q     <= '0;
                        state_q     <= StArm;
                    end
                end
                StArm: begin
                    puf_enable <= 1'b1;
                    settle_q   <= '0;
                    state_q    <= StSettle;
                end
                StSettle: begin
                    if (settle_q == 8'(SETTLE_CYCLES - 1)) begin
                        state_q <= StSample;
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                StSample: begin
                    round_q    <= round_q + 4'd1;
                    puf_enable <= 1'b0;
                    if (round_q == 4'(SAMPLES - 1)) begin
                        key           <= maj;
                        unstable_mask <= unst;
                        key_valid     <= 1'b1;
                        state_q       <= StDone;
                    end else begin
                        state_q <= StArm;
                    end
                end
                StDone: begin
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_key_sampler.sv
// Randomized directed bench for puf_key_sampler against a per-bit vote-count model.
module tb_puf_key_sampler;

    localparam int N   = 7;
    localparam int S   = 4;
    localparam int P   = S + 2;
    localparam int LAT = N * P;

    typedef logic [63:0] resp_arr_t [N];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        key_ready = 1'b0;
    logic [1:0]  challenge = 2'b00;
    logic [63:0] puf_response = '0;
    logic        busy;
    logic        puf_enable;
    logic [1:0]  puf_control;
    logic [63:0] key;
    logic [63:0] unstable_mask;
    logic        key_valid;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    puf_key_sampler #(
        .SAMPLES       (N),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .challenge     (challenge),
        .busy          (busy),
        .puf_enable    (puf_enable),
        .puf_control   (puf_control),
        .puf_response  (puf_response),
        .key           (key),
        .unstable_mask (unstable_mask),
        .key_valid     (key_valid),
        .key_ready     (key_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Count ones per bit across all samples and apply the vote rules directly.
    function automatic void ref_vote(input resp_arr_t rs, output logic [63:0] k,
                                     output logic [63:0] m);
        for (int i = 0; i < 64; i++) begin
            int c = 0;
            for (int s = 0; s < N; s++) c += int'(rs[s][i]);
            k[i] = (2 * c > N);
            m[i] = (c != 0) && (c != N);
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_en"}, 64'(puf_enable), 64'd0);
        check({tag, "_ctrl"}, 64'(puf_control), 64'd0);
        check({tag, "_key"}, key, 64'd0);
        check({tag, "_mask"}, unstable_mask, 64'd0);
        check({tag, "_valid"}, 64'(key_valid), 64'd0);
    endtask

    // Response is garbage except on the cycle where the sample must be taken.
    task automatic extract(input logic [1:0] chal, input resp_arr_t rs, input int abort_at);
        logic [LAT-1:0] en_obs, en_exp, kv_obs, busy_obs, ones;
        logic           ctrl_ok;
        logic [63:0]    k_exp, m_exp;
        ones    = '1;
        ctrl_ok = 1'b1;
        ref_vote(rs, k_exp, m_exp);
        @(negedge clk);
        start        = 1'b1;
        challenge    = chal;
        puf_response = {$urandom, $urandom};
        for (int t = 0; t < LAT; t++) begin
            @(negedge clk);
            en_obs[t]   = puf_enable;
            en_exp[t]   = ((t % P) != 0);
            kv_obs[t]   = key_valid;
            busy_obs[t] = busy;
            if (puf_control !== chal) ctrl_ok = 1'b0;
            if (t == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            start        = 1'($urandom_range(0, 1));
            challenge    = 2'($urandom);
            puf_response = ((t % P) == P - 1) ? rs[t / P] : {$urandom, $urandom};
        end
        @(negedge clk);
        start = 1'b0;
        check("enable_windows", 64'(en_obs), 64'(en_exp));
        check("valid_early", 64'(kv_obs), 64'd0);
        check("busy_during", 64'(busy_obs), 64'(ones));
        check("ctrl_during", 64'(ctrl_ok), 64'd1);
        check("valid_done", 64'(key_valid), 64'd1);
        check("en_done", 64'(puf_enable), 64'd0);
        check("busy_done", 64'(busy), 64'd1);
        check("ctrl_done", 64'(puf_control), 64'(chal));
        check("key", key, k_exp);
        check("mask", unstable_mask, m_exp);
    endtask

    task automatic ack(input resp_arr_t rs, input logic [1:0] chal, input int hold);
        logic [63:0] k_exp, m_exp;
        logic        ok;
        ref_vote(rs, k_exp, m_exp);
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (key_valid !== 1'b1 || key !== k_exp || unstable_mask !== m_exp) ok = 1'b0;
        end
        check("hold_stable", 64'(ok), 64'd1);
        key_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        check("valid_after_ack", 64'(key_valid), 64'd0);
        check("busy_after_ack", 64'(busy), 64'd0);
        key_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("no_restart", 64'(busy), 64'd0);
        check("key_retained", key, k_exp);
        check("mask_retained", unstable_mask, m_exp);
        check("ctrl_retained", 64'(puf_control), 64'(chal));
    endtask

    initial begin
        resp_arr_t   rs;
        logic [1:0]  chal;
        logic [63:0] base;
        int          off0, off1;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 64'(busy), 64'd0);

        // Constant response
        for (int s = 0; s < N; s++) rs[s] = 64'hA5A5_0000_FFFF_1234;
        extract(2'b10, rs, -1);
        ack(rs, 2'b10, 1);

        // Near-threshold bits 0 and 1, rest random
        off0 = $urandom_range(0, N - 1);
        off1 = $urandom_range(0, N - 1);
        for (int s = 0; s < N; s++) begin
            rs[s]    = {$urandom, $urandom};
            rs[s][0] = (((s + off0) % N) < 4);
            rs[s][1] = (((s + off1) % N) < 3);
        end
        extract(2'b01, rs, -1);
        check("bit0_key", 64'(key[0]), 64'd1);
        check("bit1_key", 64'(key[1]), 64'd0);
        check("bits10_mask", 64'(unstable_mask[1:0]), 64'd3);
        ack(rs, 2'b01, 10);

        // Mostly-stable random responses with sparse noise
        for (int r = 0; r < 4; r++) begin
            chal = 2'($urandom);
            base = {$urandom, $urandom};
            for (int s = 0; s < N; s++) begin
                rs[s] = base ^ ({$urandom, $urandom} & {$urandom, $urandom}
                                & {$urandom, $urandom});
            end
            extract(chal, rs, -1);
            ack(rs, chal, $urandom_range(0, 4));
        end

        // Reset during the third settle window, then a clean run
        for (int s = 0; s < N; s++) rs[s] = {$urandom, $urandom};
        extract(2'b11, rs, 2 * P + 2);
        @(negedge clk);
        check("idle_after_abort", 64'(busy), 64'd0);
        base = {$urandom, $urandom};
        for (int s = 0; s < N; s++) rs[s] = base;
        extract(2'b10, rs, -1);
        ack(rs, 2'b10, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/puf_key_sampler.md
PUF_KEY_SAMPLER -- requirements
Module: puf_key_sampler

Interface
REQ-001 SHALL have parameter SAMPLES, default 7, meaning the odd number of PUF evaluations per key, legal range 3..15; an even or out-of-range value SHALL fail elaboration.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, meaning the cycles puf_enable is held high before each sample, legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a key extraction.
REQ-006 challenge  input  2  challenge applied to the PUF, captured on start acceptance.
REQ-007 busy  output  1  high from start acceptance until return to IDLE.
REQ-008 puf_enable  output  1  drives the enable input of the 64-bit PUF generator.
REQ-009 puf_control  output  2  drives the control input of the 64-bit PUF generator.
REQ-010 puf_response  input  64  raw response from the 64-bit PUF generator.
REQ-011 key  output  64  majority-voted response.
REQ-012 unstable_mask  output  64  bit set where the samples were not unanimous.
REQ-013 key_valid  output  1  key and unstable_mask are valid.
REQ-014 key_ready  input  1  consumer accepts the key.

Function
REQ-015 SHALL implement the states IDLE, ARM, SETTLE, SAMPLE and DONE.
REQ-016 IDLE with start=1 SHALL latch challenge into puf_control, clear all vote counters and the round counter, and go to ARM.
REQ-017 ARM SHALL last 1 cycle with puf_enable=0, then go to SETTLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles with puf_enable=1, then go to SAMPLE.
REQ-019 SAMPLE SHALL last 1 cycle with puf_enable=1; each per-bit counter SHALL increment where puf_response bit=1.
REQ-020 After SAMPLE, the round counter SHALL increment; the FSM SHALL go to ARM if rounds < SAMPLES, else to DONE.
REQ-021 On entry to DONE, key[i] SHALL equal 1 iff count[i] > SAMPLES/2 (integer division).
REQ-022 On entry to DONE, unstable_mask[i] SHALL equal 1 iff 0 < count[i] < SAMPLES.
REQ-023 key_valid SHALL be high exactly while in DONE; latency from the start-accept edge to key_valid high SHALL be SAMPLES*(SETTLE_CYCLES+2) cycles.
REQ-024 In DONE, key_valid with key_ready=1 SHALL return the FSM to IDLE, and key_valid SHALL be low on the next cycle.
REQ-025 key and unstable_mask SHALL hold their values until the next DONE entry or reset.
REQ-026 start SHALL be ignored outside IDLE; challenge changes after acceptance SHALL have no effect.
REQ-027 puf_enable SHALL be 0 in IDLE and DONE; puf_control SHALL hold the latched challenge in all states.
REQ-028 Vote counters SHALL be $clog2(SAMPLES+1) bits wide and SHALL never wrap.
REQ-029 busy SHALL equal (state != IDLE).
REQ-030 start and key_ready high simultaneously in DONE SHALL complete the handshake only; start SHALL NOT be accepted until IDLE.

Reset
REQ-031 rst_n low SHALL immediately force state to IDLE and clear busy, puf_enable, puf_control, key, unstable_mask, key_valid and all counters to 0, including mid-extraction.
REQ-032 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Structure
REQ-033 Package puf_pkg SHALL hold RESP_W=64, CHAL_W=2 and the state enum type.
REQ-034 Sub-module puf_bit_voter (per-bit counter, majority and unstable flag; clear and sample-enable inputs) SHALL be instantiated RESP_W times.

Verification
REQ-035 Defaults, constant response 64'hA5A5_0000_FFFF_1234, challenge 2'b10, start pulse -> key_valid after 42 cycles, key=64'hA5A5_0000_FFFF_1234, unstable_mask=0, puf_control=2'b10.
REQ-036 Bit 0 is 1 in 4 of 7 samples and bit 1 is 1 in 3 of 7 samples -> key[0]=1, key[1]=0, unstable_mask[1:0]=2'b11.
REQ-037 key_ready held low for 10 cycles in DONE -> key_valid and key stable; key_ready=1 -> key_valid=0 and busy=0 next cycle.
REQ-038 rst_n pulsed low during the 3rd SETTLE -> all outputs 0 at once; a new start yields a clean result with no residual counts.
REQ-039 start re-pulsed during SAMPLE and challenge toggled -> no restart, latency unchanged, puf_control unchanged.
REQ-040 Probe puf_enable over one extraction -> exactly 7 low-for-1 / high-for-5 windows, sampled on the last cycle of each high window.
